// File: rtl/grid_drawer.sv
// Grid drawer: maps VGA pixels to grid cells, derives the game-step tick and owns head/direction/death state.
// Define GRID_DRAWER_WRAP_EN to make border moves wrap around instead of killing the snake.
module grid_drawer #(
    parameter int          CELL_LOG2    = 3,
    parameter int          COORD_W      = 9,
    parameter int          GRID_W       = 30,
    parameter int          GRID_H       = 30,
    parameter int          TICK_DIV     = 15,
    parameter int          FRAME_LINE   = 100,
    parameter logic [15:0] BG_COLOR     = 16'h0000,
    parameter logic [15:0] DEAD_COLOR_1 = 16'hF800,
    parameter logic [15:0] DEAD_COLOR_2 = 16'hFFE0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rst_game,
    input  logic [3:0]                   mov,
    input  logic [COORD_W-1:0]           x,
    input  logic [COORD_W-1:0]           y,
    input  logic [15:0]                  entity_data,
    input  logic                         collide,
    output logic [15:0]                  pixel_data,
    output logic [COORD_W-CELL_LOG2-1:0] grid_x,
    output logic [COORD_W-CELL_LOG2-1:0] grid_y,
    output logic                         step_tick,
    output logic [$clog2(GRID_W)-1:0]    head_x,
    output logic [$clog2(GRID_H)-1:0]    head_y,
    output logic [1:0]                   dir,
    output logic                         dead
);
    localparam int GC_W  = COORD_W - CELL_LOG2;
    localparam int HX_W  = $clog2(GRID_W);
    localparam int HY_W  = $clog2(GRID_H);
    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(TICK_DIV - 1);
    localparam logic [COORD_W-1:0] LINE       = COORD_W'(FRAME_LINE);
    localparam logic [HX_W-1:0]    X_MAX      = HX_W'(GRID_W - 1);
    localparam logic [HY_W-1:0]    Y_MAX      = HY_W'(GRID_H - 1);
    localparam logic [HX_W-1:0]    X_MID      = HX_W'(GRID_W / 2);
    localparam logic [HY_W-1:0]    Y_MID      = HY_W'(GRID_H / 2);
    localparam logic [GC_W:0]      GRID_W_EXT = (GC_W + 1)'(GRID_W);
    localparam logic [GC_W:0]      GRID_H_EXT = (GC_W + 1)'(GRID_H);
    localparam logic [GC_W-1:0]    GX_LAST    = GC_W'(GRID_W - 1);
    localparam logic [GC_W-1:0]    GY_LAST    = GC_W'(GRID_H - 1);
`ifdef GRID_DRAWER_WRAP_EN
    localparam logic WRAP_EN = 1'b1;
`else
    localparam logic WRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {DIR_RIGHT = 2'b00, DIR_DOWN = 2'b01, DIR_LEFT = 2'b10, DIR_UP = 2'b11} dir_t;

    logic             line_hit, line_prev, frame_pulse, step;
    logic [CNT_W-1:0] frame_cnt;
    logic             pend_valid, col_flag, col_eff, blink, edge_hit, kill;
    dir_t             pend, dir_q, req_dir, new_dir;
    logic [HX_W-1:0]  next_x;
    logic [HY_W-1:0]  next_y;
    logic             in_grid, border;
    logic [15:0]      pixel_next;

    assign grid_x      = x[COORD_W-1:CELL_LOG2];
    assign grid_y      = y[COORD_W-1:CELL_LOG2];
    assign dir         = dir_q;
    assign line_hit    = (y == LINE);
    assign frame_pulse = line_hit & ~line_prev;
    assign step        = frame_pulse && (frame_cnt == CNT_LAST);
    assign col_eff     = col_flag | collide;
    assign kill        = col_eff | (edge_hit & ~WRAP_EN);

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        req_dir = DIR_UP;
        if (mov[0])      req_dir = DIR_RIGHT;
        else if (mov[1]) req_dir = DIR_DOWN;
        else if (mov[2]) req_dir = DIR_LEFT;
    end

    // A pending request that reverses the current heading is dropped.
    always_comb begin
        new_dir = dir_q;
        if (pend_valid && (2'(pend) != (2'(dir_q) ^ 2'b10)))
            new_dir = pend;
    end

    // Candidate head: edge_hit flags a border crossing; next_* holds the wrapped cell.
    always_comb begin
        next_x   = head_x;
        next_y   = head_y;
        edge_hit = 1'b0;
        case (new_dir)
            DIR_RIGHT: if (head_x == X_MAX) begin edge_hit = 1'b1; next_x = '0;    end
                       else next_x = head_x + HX_W'(1);
            DIR_LEFT:  if (head_x == '0)    begin edge_hit = 1'b1; next_x = X_MAX; end
                       else next_x = head_x - HX_W'(1);
            DIR_DOWN:  if (head_y == Y_MAX) begin edge_hit = 1'b1; next_y = '0;    end
                       else next_y = head_y + HY_W'(1);
            DIR_UP:    if (head_y == '0)    begin edge_hit = 1'b1; next_y = Y_MAX; end
                       else next_y = head_y - HY_W'(1);
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_prev  <= 1'b0;
            frame_cnt  <= '0;
            step_tick  <= 1'b0;
            head_x     <= X_MID;
            head_y     <= Y_MID;
            dir_q      <= DIR_RIGHT;
            pend       <= DIR_RIGHT;
            pend_valid <= 1'b0;
            col_flag   <= 1'b0;
            dead       <= 1'b0;
            blink      <= 1'b0;
        end else begin
            line_prev <= line_hit;
            if (rst_game) begin
                frame_cnt  <= '0;
                step_tick  <= 1'b0;
                head_x     <= X_MID;
                head_y     <= Y_MID;
                dir_q      <= DIR_RIGHT;
                pend_valid <= 1'b0;
                col_flag   <= 1'b0;
                dead       <= 1'b0;
                blink      <= 1'b0;
            end else begin
                step_tick <= step;
                if (frame_pulse)
                    frame_cnt <= step ? '0 : frame_cnt + CNT_W'(1);
                if (step) begin
                    pend_valid <= 1'b0;
                    col_flag   <= 1'b0;
                    if (dead) begin
                        blink <= ~blink;
                    end else begin
                        dir_q <= new_dir;
                        if (kill) begin
                            dead <= 1'b1;
                        end else begin
                            head_x <= next_x;
                            head_y <= next_y;
                        end
                    end
                end else if (collide) begin
                    col_flag <= 1'b1;
                end
                // A request on the step edge survives the clear and feeds the next step.
                if (mov != 4'b0000) begin
                    pend       <= req_dir;
                    pend_valid <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        in_grid    = ({1'b0, grid_x} < GRID_W_EXT) && ({1'b0, grid_y} < GRID_H_EXT);
        border     = (grid_x == '0) || (grid_x == GX_LAST) || (grid_y == '0) || (grid_y == GY_LAST);
        pixel_next = entity_data;
        if (!in_grid)
            pixel_next = BG_COLOR;
        else if (dead)
            pixel_next = border ? (blink ? DEAD_COLOR_1 : DEAD_COLOR_2) : BG_COLOR;
    end

    // The pixel pipeline ignores rst_game; only the hard reset clears it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pixel_data <= '0;
        else     pixel_data <= pixel_next;
    end
endmodule

// File: doc/grid_drawer.md
# grid_drawer

Parametrised single-clock successor to the fixed 30×30 snake drawer. Maps VGA pixel coordinates to grid cells, generates the game-step tick from a frame-line detector and divider, owns head position, direction and death state, and produces the registered 16-bit pixel colour. It sits between the VGA timing generator (`x`/`y`) and the snake controller (`grid_x`/`grid_y`/`step_tick` out, `entity_data`/`collide` in). All derived clocks are replaced by clock enables.

## Interface
- `CELL_LOG2`, 3: log2 of cell size in pixels.
- `COORD_W`, 9: width of `x`/`y`.
- `GRID_W`, 30: grid width in cells (2..2^(COORD_W-CELL_LOG2)).
- `GRID_H`, 30: grid height in cells.
- `TICK_DIV`, 15: frames per game step (≥1).
- `FRAME_LINE`, 100: `y` value marking frame start.
- `BG_COLOR`, 16'h0000: background and out-of-grid colour.
- `DEAD_COLOR_1`, 16'hF800: border blink colour, phase 1.
- `DEAD_COLOR_2`, 16'hFFE0: border blink colour, phase 0.
- `clk` in 1: pixel clock. `rst` in 1: asynchronous, active-high reset.
- `rst_game` in 1: synchronous game restart; the pixel register is unaffected.
- `mov` in 4: direction requests; bits 0–3 = right, down, left, up.
- `x`, `y` in COORD_W: current pixel.
- `entity_data` in 16: cell colour from the snake controller.
- `collide` in 1: self-collision pulse from the controller.
- `pixel_data` out 16: registered pixel colour.
- `grid_x`, `grid_y` out COORD_W-CELL_LOG2: `x`/`y` >> CELL_LOG2, combinational.
- `step_tick` out 1: one-cycle game-step pulse.
- `head_x`, `head_y` out $clog2(GRID_W) / $clog2(GRID_H): head cell.
- `dir` out 2: 00 right, 01 down, 10 left, 11 up.
- `dead` out 1: game-over flag.

## Operation
- Frame pulse: `y == FRAME_LINE` while the registered previous-cycle compare is 0. One cycle per frame, not the level.
- Frame counter 0..TICK_DIV-1 advances on the frame pulse. At TICK_DIV-1 it wraps to 0 and a step occurs.
- Direction request: when `mov` ≠ 0, latch the lowest set bit's direction into `pend` (valid bit set); a later request overwrites it. At a step, apply `pend` unless it equals `dir ^ 2'b10` (reversal, ignored). Clear the valid bit at every step.
- Step, alive: move the head one cell in the new `dir`. Stepping off the grid (x=0 left, x=GRID_W-1 right, same for y) sets `dead`; the head holds. A sticky `collide` flag (set by `collide`, cleared at step) sets `dead` at the step; the head holds.
- Step, dead: the head is frozen and the `blink` bit toggles.
- Pixel select: if out of grid (`grid_x` ≥ GRID_W or `grid_y` ≥ GRID_H), the colour is BG_COLOR. Otherwise, if `dead`, border cells (x=0, x=GRID_W-1, y=0, y=GRID_H-1) show DEAD_COLOR_1 when `blink`=1 and DEAD_COLOR_2 when `blink`=0; the interior shows BG_COLOR. Otherwise the colour is `entity_data`.
- `rst_game` priority over a coincident step: head to (GRID_W/2, GRID_H/2), `dir` 00, `pend` invalid, `dead` 0, `blink` 0, frame counter 0, collide flag 0.

## Timing
- Reset values: `pixel_data` 0, `step_tick` 0, `head` (GRID_W/2, GRID_H/2), `dir` 00, `dead` 0. Internal: `blink` 0, counter 0, `pend` invalid, prev-compare 0.
- `pixel_data` latency is 1 cycle from `x`/`y`/`entity_data`.
- A step is taken at the clock edge where the frame pulse occurs with counter = TICK_DIV-1. `step_tick`, the new head, `dir`, `dead` and `blink` are all visible in the following cycle.
- `mov` in the same cycle as the step edge is not applied to that step; it is latched for the next one.
- `collide` in the step cycle counts toward that step.
- TICK_DIV=1: a step on every frame pulse.
- `rst` mid-operation clears all state immediately. The first frame pulse needs a fresh rising compare.

## Configuration
- `GRID_DRAWER_WRAP_EN` defined: border moves wrap around (x=GRID_W-1 right → 0, 0 left → GRID_W-1, same for y). Only `collide` can set `dead`.
- Undefined: border moves set `dead` as above.

## Test plan
- Reset, then 15 frame pulses, `mov`=0 → exactly one `step_tick`; head goes (15,15)→(16,15).
- `mov`=4'b0010 then 4'b0100 before a step while moving right → left is a reversal and is ignored; `dir` stays 00.
- `mov`=4'b0011 → lowest bit wins: `dir`=00.
- Head at (29,15) moving right, wrap undefined → `dead`=1, head holds. Pixel at (0,0) is DEAD_COLOR_2, then DEAD_COLOR_1 after the next step. Pixel (240,0) (out of grid) stays BG_COLOR.
- Same with `GRID_DRAWER_WRAP_EN` → head (0,15), `dead`=0.
- `y` held at FRAME_LINE for 800 cycles → one frame pulse. `rst_game` on the step edge → head (15,15), no move, `dead`=0.
